pow_target_check: RTL and testbench



---
 rtl/pow_cmp_pkg.sv | 16 +
 rtl/digit_cmp.sv | 20 ++
 rtl/pow_target_check.sv | 118 +++++++++++
 tb/tb_pow_target_check.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pow_cmp_pkg.sv
// Shared definitions for the proof-of-work target comparator:
// FSM state encodings and bit positions of the one-hot result vector.
package pow_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Positions inside the registered {gt, eq, lt} result vector
  localparam int RES_LT = 0;
  localparam int RES_EQ = 1;
  localparam int RES_GT = 2;

endpackage : pow_cmp_pkg

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of two DIGIT-bit values.
// Exactly one of eq/gt/lt is high for any input pair.
module digit_cmp #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  // Plain magnitude compare; synthesis maps this onto a small comparator
  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule : digit_cmp

// File: rtl/pow_target_check.sv
// Proof-of-work decision stage. Walks hash and target MSB-first one
// digit per clock and stops at the first differing digit, reporting
// hash < target (meets), equal or greater as a one-hot result.
module pow_target_check
  import pow_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] hash,
  input  logic [WIDTH-1:0] target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             meets,
  output logic             equal,
  output logic             greater,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hsr_reg, hsr_next;
  logic [WIDTH-1:0] tsr_reg, tsr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2:0]       res_reg, res_next;

  logic d_eq, d_gt, d_lt;

  // The digit under test is always the top DIGIT bits; the operands
  // shift left instead of the compare point moving down the word.
  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a  (hsr_reg[WIDTH-1 -: DIGIT]),
    .b  (tsr_reg[WIDTH-1 -: DIGIT]),
    .eq (d_eq),
    .gt (d_gt),
    .lt (d_lt)
  );

  // State, operand shift registers, digit counter and result bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      hsr_reg   <= '0;
      tsr_reg   <= '0;
      cnt_reg   <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hsr_reg   <= hsr_next;
      tsr_reg   <= tsr_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
    end
  end

  // Next-state logic: accept in IDLE, early-exit scan, hold until taken
  always_comb begin
    state_next = state_reg;
    hsr_next   = hsr_reg;
    tsr_next   = tsr_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          hsr_next   = hash;
          tsr_next   = target;
          cnt_next   = CW'(N - 1);
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!d_eq) begin
          // First differing digit alone decides the unsigned order
          res_next         = '0;
          res_next[RES_LT] = d_lt;
          res_next[RES_GT] = d_gt;
          state_next       = ST_DONE;
        end else if (cnt_reg == '0) begin
          res_next         = '0;
          res_next[RES_EQ] = 1'b1;
          state_next       = ST_DONE;
        end else begin
          hsr_next = hsr_reg << DIGIT;
          tsr_next = tsr_reg << DIGIT;
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          res_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        res_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decode straight from the state register
  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
    busy      = (state_reg == ST_SCAN) || (state_reg == ST_DONE);
    meets     = res_reg[RES_LT];
    equal     = res_reg[RES_EQ];
    greater   = res_reg[RES_GT];
  end

endmodule : pow_target_check

// File: tb/tb_pow_target_check.sv
// Directed bench for pow_target_check: three instances (8/1, 8/4, 32/1),
// hand-computed results and latencies, plus a scoreboarded 32-bit stream.
module tb_pow_target_check;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]  in_valid_v  = '0;
  logic [2:0]  out_ready_v = '0;
  logic [31:0] hash_v   [3];
  logic [31:0] target_v [3];
  logic [2:0]  in_ready_v, out_valid_v, meets_v, equal_v, greater_v, busy_v;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  pow_target_check #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .hash(hash_v[0][7:0]), .target(target_v[0][7:0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .meets(meets_v[0]), .equal(equal_v[0]), .greater(greater_v[0]), .busy(busy_v[0])
  );

  pow_target_check #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .hash(hash_v[1][7:0]), .target(target_v[1][7:0]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .meets(meets_v[1]), .equal(equal_v[1]), .greater(greater_v[1]), .busy(busy_v[1])
  );

  pow_target_check #(.WIDTH(32), .DIGIT(1)) u_w32d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .hash(hash_v[2]), .target(target_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .meets(meets_v[2]), .equal(equal_v[2]), .greater(greater_v[2]), .busy(busy_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input int d);
    return {greater_v[d], equal_v[d], meets_v[d]};
  endfunction

  // One transaction on instance d. After the accept edge in_valid stays
  // high with inverted operands, which the block must ignore. out_ready
  // is withheld for 'hold' cycles once the result appears.
  task automatic transact(input int d, input logic [31:0] h, input logic [31:0] t,
                          input logic [2:0] exp_res, input int exp_lat,
                          input int hold, input string tag);
    int lat;
    hash_v[d]      = h;
    target_v[d]    = t;
    in_valid_v[d]  = 1'b1;
    out_ready_v[d] = (hold == 0);
    check({tag, " in_ready_idle"}, {31'd0, in_ready_v[d]}, 32'd1);
    @(posedge clk); #1;
    hash_v[d]   = ~h;
    target_v[d] = ~t;
    lat = 0;
    while (!out_valid_v[d] && lat < 64) begin
      check({tag, " in_ready_scan"}, {31'd0, in_ready_v[d]}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, {29'd0, res_of(d)}, {29'd0, exp_res});
    check({tag, " busy_done"}, {31'd0, busy_v[d]}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold_valid"}, {31'd0, out_valid_v[d]}, 32'd1);
      check({tag, " hold_result"}, {29'd0, res_of(d)}, {29'd0, exp_res});
      check({tag, " hold_in_ready"}, {31'd0, in_ready_v[d]}, 32'd0);
    end
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d]  = 1'b0;
    out_ready_v[d] = 1'b0;
    check({tag, " post_valid"}, {31'd0, out_valid_v[d]}, 32'd0);
    check({tag, " post_result"}, {29'd0, res_of(d)}, 32'd0);
    check({tag, " post_in_ready"}, {31'd0, in_ready_v[d]}, 32'd1);
    check({tag, " post_busy"}, {31'd0, busy_v[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] h, t, x;
    logic [2:0]  er;
    int          el;
    for (int d = 0; d < 3; d++) begin
      hash_v[d]   = '0;
      target_v[d] = '0;
    end

    // Reset state
    #12;
    for (int d = 0; d < 3; d++) begin
      check("rst out_valid", {31'd0, out_valid_v[d]}, 32'd0);
      check("rst result", {29'd0, res_of(d)}, 32'd0);
      check("rst busy", {31'd0, busy_v[d]}, 32'd0);
      check("rst in_ready", {31'd0, in_ready_v[d]}, 32'd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed 8-bit, 1-bit digits
    transact(0, 32'h3C, 32'h40, 3'b001, 2, 0, "w8d1_lt");
    transact(0, 32'hA5, 32'hA5, 3'b010, 8, 0, "w8d1_eq");
    transact(0, 32'h80, 32'h7F, 3'b100, 1, 5, "w8d1_gt_hold");
    transact(0, 32'h7F, 32'h80, 3'b001, 1, 0, "w8d1_second_pair");

    // 8-bit, 4-bit digits
    transact(1, 32'h3C, 32'h40, 3'b001, 1, 0, "w8d4_lt");
    transact(1, 32'h4F, 32'h40, 3'b100, 2, 0, "w8d4_gt");
    transact(1, 32'h5A, 32'h5A, 3'b010, 2, 2, "w8d4_eq");

    // Reset three clocks after accept aborts the pair
    hash_v[0]   = 32'h01;
    target_v[0] = 32'h01;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_v[0]}, 32'd0);
    check("abort result", {29'd0, res_of(0)}, 32'd0);
    check("abort out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    check("abort in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("abort no_valid", {31'd0, out_valid_v[0]}, 32'd0);
    end
    transact(0, 32'h00, 32'h01, 3'b001, 8, 0, "w8d1_after_rst");

    // 32-bit scoreboarded stream with random backpressure
    for (int i = 0; i < 200; i++) begin
      h = $urandom;
      case (i % 4)
        0:       t = h;
        1:       t = h ^ (32'h1 << $urandom_range(31, 0));
        default: t = $urandom;
      endcase
      er = (h < t) ? 3'b001 : (h == t) ? 3'b010 : 3'b100;
      x  = h ^ t;
      el = 32;
      for (int b = 31; b >= 0; b--) begin
        if (x[b]) begin
          el = 32 - b;
          break;
        end
      end
      transact(2, h, t, er, el, $urandom_range(3, 0), "w32d1_stream");
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_pow_target_check
